mem_arbiter: RTL and testbench

- Sits directly downstream of the icache and dcache, between both caches and the single-ported RAM.
- Grants one cache a RAM transaction at a time and forwards address, data and enables to the RAM.
- Returns load data and per-cache wait signals to the caches.
- dcache has priority; a streak limiter stops icache starvation. Saturating performance counters are also maintained.

---
 rtl/cpu_types_pkg.sv | 19 +
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word bus, RAM status and memory-arbiter grant states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DGRANT = 2'b01,
    IGRANT = 2'b10
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported RAM between icache and dcache: dcache first,
// with a streak limit so a waiting icache is eventually let in.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             iREN,
  input  word_t            iaddr,
  output word_t            iload,
  output logic             iwait,
  input  logic             dREN,
  input  logic             dWEN,
  input  word_t            daddr,
  input  word_t            dstore,
  output word_t            dload,
  output logic             dwait,
  output logic             ramREN,
  output logic             ramWEN,
  output word_t            ramaddr,
  output word_t            ramstore,
  input  word_t            ramload,
  input  ramstate_t        ramstate,
  output logic             ram_err,
  output logic [CNT_W-1:0] dgrant_cnt,
  output logic [CNT_W-1:0] igrant_cnt
);

  localparam int unsigned         STREAK_W   = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
  localparam logic [CNT_W-1:0]    CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
  localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

  arb_state_t          state_r;
  arb_state_t          next_state_s;
  logic [STREAK_W-1:0] dstreak_r;
  logic                done_s;
  logic                d_req_s;
  logic                ram_done_s;

  assign d_req_s    = dREN | dWEN;
  assign ram_done_s = (ramstate == ACCESS) || (ramstate == ERROR);

  // Next-state selection and combinational forwarding between caches and RAM.
  always_comb begin
    next_state_s = state_r;
    done_s       = 1'b0;
    iwait        = 1'b1;
    dwait        = 1'b1;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = 32'h0000_0000;
    ramstore     = 32'h0000_0000;
    iload        = 32'h0000_0000;
    dload        = 32'h0000_0000;
    // Reset forces the idle view immediately, even mid-grant.
    if (RST) begin
      next_state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (d_req_s && !(iREN && (dstreak_r == STREAK_MAX))) begin
            next_state_s = DGRANT;
          end else if (iREN) begin
            next_state_s = IGRANT;
          end else begin
            next_state_s = IDLE;
          end
        end
        DGRANT: begin
          ramaddr  = daddr;
          ramstore = dstore;
          dload    = ramload;
          if (dWEN) begin
            ramWEN = 1'b1;
          end else begin
            ramREN = dREN;
          end
          if (!d_req_s) begin
            next_state_s = IDLE;
          end else if (ram_done_s) begin
            done_s       = 1'b1;
            dwait        = 1'b0;
            next_state_s = IDLE;
          end else begin
            next_state_s = DGRANT;
          end
        end
        IGRANT: begin
          ramaddr = iaddr;
          ramREN  = iREN;
          iload   = ramload;
          if (!iREN) begin
            next_state_s = IDLE;
          end else if (ram_done_s) begin
            done_s       = 1'b1;
            iwait        = 1'b0;
            next_state_s = IDLE;
          end else begin
            next_state_s = IGRANT;
          end
        end
        default: begin
          next_state_s = IDLE;
        end
      endcase
    end
  end

  // Grant state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Sticky error flag and saturating completion counters; errors do not count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ram_err    <= 1'b0;
      dgrant_cnt <= {CNT_W{1'b0}};
      igrant_cnt <= {CNT_W{1'b0}};
    end else if (done_s && (ramstate == ERROR)) begin
      ram_err <= 1'b1;
    end else if (done_s && (state_r == DGRANT) && (dgrant_cnt != CNT_MAX)) begin
      dgrant_cnt <= dgrant_cnt + CNT_ONE;
    end else if (done_s && (state_r == IGRANT) && (igrant_cnt != CNT_MAX)) begin
      igrant_cnt <= igrant_cnt + CNT_ONE;
    end else begin
      ram_err <= ram_err;
    end
  end

  // Consecutive dcache completions seen while the icache is waiting.
  always_ff @(posedge CLK) begin
    if (RST) begin
      dstreak_r <= {STREAK_W{1'b0}};
    end else if (done_s && (state_r == DGRANT) && iREN) begin
      if (dstreak_r != STREAK_MAX) begin
        dstreak_r <= dstreak_r + STREAK_ONE;
      end else begin
        dstreak_r <= dstreak_r;
      end
    end else if (done_s && (state_r == IGRANT)) begin
      dstreak_r <= {STREAK_W{1'b0}};
    end else if ((state_r == IDLE) && !iREN) begin
      dstreak_r <= {STREAK_W{1'b0}};
    end else begin
      dstreak_r <= dstreak_r;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int CW   = 4;
  localparam int MAXS = 4;

  logic          CLK, RST, iREN, dREN, dWEN;
  word_t         iaddr, daddr, dstore, ramload;
  ramstate_t     ramstate;
  word_t         iload, dload, ramaddr, ramstore;
  logic          iwait, dwait, ramREN, ramWEN, ram_err;
  logic [CW-1:0] dgrant_cnt, igrant_cnt;

  mem_arbiter #(.MAX_D_STREAK(MAXS), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .ram_err(ram_err),
    .dgrant_cnt(dgrant_cnt), .igrant_cnt(igrant_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cmp_cnt = 0;
  int err_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the RAM (0 none, 1 dcache, 2 icache) and totals.
  int   m_owner = 0;
  int   m_streak = 0;
  int   m_dcnt = 0;
  int   m_icnt = 0;
  logic m_err = 1'b0;
  bit   d_done_last, i_done_last;

  logic  s_iwait, s_dwait, s_ramREN, s_ramWEN, s_ram_err;
  word_t s_ramaddr, s_ramstore, s_iload, s_dload;
  int    s_dcnt, s_icnt;

  // One clock: check at the falling edge, advance the model at the rising edge.
  task automatic tick();
    bit    d_act, i_act, act, fin;
    logic  e_ren, e_wen;
    word_t e_addr, e_store, e_iload, e_dload;
    @(negedge CLK);
    d_act = dREN | dWEN;
    i_act = iREN;
    act = !RST && ((m_owner == 1) ? d_act : (m_owner == 2) ? i_act : 1'b0);
    fin = act && (ramstate == ACCESS || ramstate == ERROR);
    e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0; e_iload = '0; e_dload = '0;
    if (!RST && m_owner == 1) begin
      e_addr = daddr; e_store = dstore; e_dload = ramload;
      e_wen = dWEN; e_ren = dREN & ~dWEN;
    end else if (!RST && m_owner == 2) begin
      e_addr = iaddr; e_iload = ramload; e_ren = iREN;
    end
    s_iwait = iwait; s_dwait = dwait; s_ramREN = ramREN; s_ramWEN = ramWEN;
    s_ramaddr = ramaddr; s_ramstore = ramstore; s_iload = iload; s_dload = dload;
    s_ram_err = ram_err; s_dcnt = int'(dgrant_cnt); s_icnt = int'(igrant_cnt);
    check_eq("iwait",    32'(s_iwait),  32'(!(fin && m_owner == 2)));
    check_eq("dwait",    32'(s_dwait),  32'(!(fin && m_owner == 1)));
    check_eq("ramREN",   32'(s_ramREN), 32'(e_ren));
    check_eq("ramWEN",   32'(s_ramWEN), 32'(e_wen));
    check_eq("ramaddr",  s_ramaddr,  e_addr);
    check_eq("ramstore", s_ramstore, e_store);
    check_eq("iload",    s_iload,    e_iload);
    check_eq("dload",    s_dload,    e_dload);
    check_eq("ram_err",  32'(s_ram_err), 32'(m_err));
    check_eq("dgrant_cnt", 32'(s_dcnt), 32'(m_dcnt));
    check_eq("igrant_cnt", 32'(s_icnt), 32'(m_icnt));
    d_done_last = fin && m_owner == 1;
    i_done_last = fin && m_owner == 2;
    @(posedge CLK);
    if (RST) begin
      m_owner = 0; m_streak = 0; m_dcnt = 0; m_icnt = 0; m_err = 1'b0;
    end else if (m_owner == 0) begin
      if (!i_act) m_streak = 0;
      if (d_act && !(i_act && m_streak == MAXS)) m_owner = 1;
      else if (i_act) m_owner = 2;
    end else if (fin) begin
      if (ramstate == ERROR) m_err = 1'b1;
      else if (m_owner == 1) m_dcnt = (m_dcnt < 15) ? m_dcnt + 1 : 15;
      else m_icnt = (m_icnt < 15) ? m_icnt + 1 : 15;
      if (m_owner == 1 && i_act) m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
      if (m_owner == 2) m_streak = 0;
      m_owner = 0;
    end else if (!act) begin
      m_owner = 0;
    end
    #1;
  endtask

  bit        d_pend, i_pend, abort_now;
  int        n_done, dc_save, r;
  logic [9:0] pattern;

  initial begin
    RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;

    // reset
    tick(); tick();
    check_eq("rst_iwait", 32'(s_iwait), 32'd1);
    check_eq("rst_dwait", 32'(s_dwait), 32'd1);
    check_eq("rst_ramREN", 32'(s_ramREN), 32'd0);
    check_eq("rst_dcnt", 32'(s_dcnt), 32'd0);

    // dcache read with two BUSY cycles
    RST = 1'b0; dREN = 1'b1; daddr = 32'h40; tick();
    ramstate = BUSY; tick(); tick();
    ramstate = ACCESS; ramload = 32'hDEADBEEF; tick();
    check_eq("rd_dload", s_dload, 32'hDEADBEEF);
    check_eq("rd_dwait", 32'(s_dwait), 32'd0);
    check_eq("rd_iwait", 32'(s_iwait), 32'd1);
    dREN = 1'b0; ramstate = FREE; tick();
    check_eq("rd_dcnt", 32'(s_dcnt), 32'd1);

    // simultaneous write and instruction fetch
    dWEN = 1'b1; daddr = 32'h80; dstore = 32'h12345678; iREN = 1'b1; iaddr = 32'h100;
    tick();
    ramstate = ACCESS; tick();
    check_eq("sim_ramWEN", 32'(s_ramWEN), 32'd1);
    check_eq("sim_ramstore", s_ramstore, 32'h12345678);
    check_eq("sim_dwait", 32'(s_dwait), 32'd0);
    dWEN = 1'b0; ramstate = FREE; tick();
    check_eq("sim_idle_ren", 32'(s_ramREN), 32'd0);
    tick();
    check_eq("sim_igrant_ren", 32'(s_ramREN), 32'd1);
    check_eq("sim_igrant_addr", s_ramaddr, 32'h100);
    ramstate = ACCESS; ramload = 32'hCAFEF00D; tick();
    check_eq("sim_iload", s_iload, 32'hCAFEF00D);
    check_eq("sim_iwait", 32'(s_iwait), 32'd0);
    iREN = 1'b0; ramstate = FREE; tick();

    // starvation guard: D,D,D,D,I twice
    dREN = 1'b1; daddr = 32'h200; iREN = 1'b1; iaddr = 32'h300; ramstate = ACCESS;
    n_done = 0; pattern = '0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (!s_dwait) begin pattern = {pattern[8:0], 1'b1}; n_done++; end
      if (!s_iwait) begin pattern = {pattern[8:0], 1'b0}; n_done++; end
    end
    check_eq("streak_count", 32'(n_done), 32'd10);
    check_eq("streak_order", 32'(pattern), 32'(10'b1111011110));
    dREN = 1'b0; iREN = 1'b0; ramstate = FREE; tick();

    // ERROR completion
    dc_save = s_dcnt;
    dREN = 1'b1; daddr = 32'h44; tick();
    ramstate = ERROR; tick();
    check_eq("err_dwait", 32'(s_dwait), 32'd0);
    dREN = 1'b0; ramstate = FREE; tick();
    check_eq("err_flag", 32'(s_ram_err), 32'd1);
    check_eq("err_dcnt", 32'(s_dcnt), 32'(dc_save));
    tick(); tick();
    check_eq("err_sticky", 32'(s_ram_err), 32'd1);

    // abort during BUSY
    dREN = 1'b1; daddr = 32'h48; tick();
    ramstate = BUSY; tick();
    check_eq("abort_ren", 32'(s_ramREN), 32'd1);
    dREN = 1'b0; tick();
    dREN = 1'b1; ramstate = ACCESS; tick();
    check_eq("abort_idle", 32'(s_dwait), 32'd1);
    check_eq("abort_dcnt", 32'(s_dcnt), 32'(dc_save));
    tick();
    check_eq("abort_regrant", 32'(s_dwait), 32'd0);
    dREN = 1'b0; ramstate = FREE; tick();

    // reset during IGRANT
    iREN = 1'b1; iaddr = 32'h500; tick();
    ramstate = BUSY; tick();
    check_eq("rstg_ren", 32'(s_ramREN), 32'd1);
    RST = 1'b1; tick();
    check_eq("rstg_drop", 32'(s_ramREN), 32'd0);
    RST = 1'b0; ramstate = ACCESS; tick();
    check_eq("rstg_idle_ren", 32'(s_ramREN), 32'd0);
    check_eq("rstg_idle_iwait", 32'(s_iwait), 32'd1);
    check_eq("rstg_err_clr", 32'(s_ram_err), 32'd0);
    iREN = 1'b0; ramstate = FREE; tick();

    // random traffic
    d_pend = 1'b0; i_pend = 1'b0;
    for (int k = 0; k < 600; k++) begin
      abort_now = 1'b0;
      RST = ($urandom_range(0, 99) == 0);
      if (d_pend) begin
        if (d_done_last) begin
          d_pend = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        end else if ($urandom_range(0, 29) == 0) begin
          d_pend = 1'b0; dREN = 1'b0; dWEN = 1'b0; abort_now = 1'b1;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        d_pend = 1'b1;
        r = $urandom_range(1, 3);
        dREN = r[0]; dWEN = r[1];
        daddr = $urandom; dstore = $urandom;
      end
      if (i_pend) begin
        if (i_done_last) begin
          i_pend = 1'b0; iREN = 1'b0;
        end else if ($urandom_range(0, 29) == 0) begin
          i_pend = 1'b0; iREN = 1'b0; abort_now = 1'b1;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        i_pend = 1'b1; iREN = 1'b1; iaddr = $urandom;
      end
      r = $urandom_range(0, 9);
      if (abort_now) ramstate = (r < 5) ? FREE : BUSY;
      else if (r < 3) ramstate = FREE;
      else if (r < 6) ramstate = BUSY;
      else if (r < 9) ramstate = ACCESS;
      else ramstate = ERROR;
      ramload = $urandom;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
